// File: rtl/riscv_vec_pkg.sv
// Shared definitions for the riscvvec vector ALU sequencer: opcodes,
// default geometry, sequencer states and small opcode helpers.
package riscv_vec_pkg;

  localparam int unsigned VEC_NLANES = 8;
  localparam int unsigned VEC_LANE_W = 32;

  localparam logic [3:0] VFN_ADDV   = 4'd0;
  localparam logic [3:0] VFN_SUBV   = 4'd1;
  localparam logic [3:0] VFN_SLTV   = 4'd2;
  localparam logic [3:0] VFN_SEQV   = 4'd3;
  localparam logic [3:0] VFN_ANDV   = 4'd4;
  localparam logic [3:0] VFN_ADDX   = 4'd5;
  localparam logic [3:0] VFN_SUBX   = 4'd6;
  localparam logic [3:0] VFN_SLTX   = 4'd7;
  localparam logic [3:0] VFN_SEQX   = 4'd8;
  localparam logic [3:0] VFN_ANDX   = 4'd9;
  localparam logic [3:0] VFN_REDSUM = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  // X variants take the scalar operand in place of vector B
  function automatic logic fn_is_x(input logic [3:0] fn);
    return (fn >= VFN_ADDX) && (fn <= VFN_ANDX);
  endfunction

  function automatic logic fn_is_illegal(input logic [3:0] fn);
    return fn > VFN_REDSUM;
  endfunction

endpackage

// File: rtl/riscv_vec_alu_seq_if.sv
// Request/response channel between vector issue and the ALU sequencer.
interface riscv_vec_alu_seq_if #(
  parameter int unsigned NLANES = 8,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned VLW    = 4
);
  logic                     req_val;
  logic                     req_rdy;
  logic [3:0]               req_fn;
  logic [NLANES*LANE_W-1:0] req_vec_a;
  logic [NLANES*LANE_W-1:0] req_vec_b;
  logic [LANE_W-1:0]        req_scalar;
  logic [NLANES-1:0]        req_vm;
  logic [VLW-1:0]           req_vl;
  logic [NLANES*LANE_W-1:0] req_vd_old;
  logic                     resp_val;
  logic                     resp_rdy;
  logic [NLANES*LANE_W-1:0] resp_vec;
  logic                     resp_err;

  modport master (
    output req_val, req_fn, req_vec_a, req_vec_b, req_scalar, req_vm,
           req_vl, req_vd_old, resp_rdy,
    input  req_rdy, resp_val, resp_vec, resp_err
  );

  modport slave (
    input  req_val, req_fn, req_vec_a, req_vec_b, req_scalar, req_vm,
           req_vl, req_vd_old, resp_rdy,
    output req_rdy, resp_val, resp_vec, resp_err
  );
endinterface

// File: rtl/riscv_vec_lane_alu.sv
// Single-element combinational ALU. REDSUM is an add: the sequencer feeds
// the running accumulator on b.
module riscv_vec_lane_alu
  import riscv_vec_pkg::*;
#(
  parameter int unsigned LANE_W = 32
) (
  input  logic [3:0]        fn,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] result,
  output logic              illegal
);

  // Decode the operation; undefined codes yield 0 and flag illegal
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (fn)
      VFN_ADDV, VFN_ADDX, VFN_REDSUM: result = a + b;
      VFN_SUBV, VFN_SUBX:             result = a - b;
      VFN_SLTV, VFN_SLTX:             result = LANE_W'($signed(a) < $signed(b));
      VFN_SEQV, VFN_SEQX:             result = LANE_W'(a == b);
      VFN_ANDV, VFN_ANDX:             result = a & b;
      default:                        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_vec_alu_seq.sv
// Lane-serial vector ALU sequencer: latches one request, walks one element
// per cycle through a shared lane ALU, and returns the assembled vector.
module riscv_vec_alu_seq
  import riscv_vec_pkg::*;
#(
  parameter int unsigned NLANES = VEC_NLANES,
  parameter int unsigned LANE_W = VEC_LANE_W,
  parameter int unsigned VLW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kill,
  output logic                busy,
  riscv_vec_alu_seq_if.slave  io
);

  localparam int unsigned IW = (NLANES > 1) ? $clog2(NLANES) : 1;

  seq_state_e state_q, state_d;

  logic [NLANES-1:0][LANE_W-1:0] a_r, b_r, res_r;
  logic [LANE_W-1:0]             scalar_r, acc_r;
  logic [NLANES-1:0]             vm_r;
  logic [VLW-1:0]                vl_r;
  logic [3:0]                    fn_r;
  logic [IW-1:0]                 idx_r;
  logic                          err_r;

  logic [VLW-1:0]    vl_clamp;
  logic              accept;
  logic              last;
  logic [LANE_W-1:0] alu_b;
  logic [LANE_W-1:0] alu_res;
  logic              alu_illegal;

  assign vl_clamp = (io.req_vl > VLW'(NLANES)) ? VLW'(NLANES) : io.req_vl;
  assign accept   = (state_q == ST_IDLE) && io.req_val && !kill;
  assign last     = (VLW'(idx_r) == (vl_r - VLW'(1)));

  assign io.req_rdy  = (state_q == ST_IDLE);
  assign io.resp_val = (state_q == ST_DONE);
  assign io.resp_vec = res_r;
  assign io.resp_err = err_r;
  assign busy        = (state_q != ST_IDLE);

  // Select the second ALU operand: accumulator, scalar or element of B
  always_comb begin
    alu_b = b_r[idx_r];
    if (fn_r == VFN_REDSUM)
      alu_b = acc_r;
    else if (fn_is_x(fn_r))
      alu_b = scalar_r;
  end

  riscv_vec_lane_alu #(.LANE_W(LANE_W)) u_lane_alu (
    .fn      (fn_r),
    .a       (a_r[idx_r]),
    .b       (alu_b),
    .result  (alu_res),
    .illegal (alu_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; kill wins over both acceptance and resp_rdy
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (vl_clamp == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (kill) state_d = ST_IDLE;
               else if (last) state_d = ST_DONE;
      ST_DONE: if (kill || io.resp_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch and per-element result write. The result register is
  // preloaded with vd_old (or zeros for REDSUM) so inactive and
  // beyond-vl elements need no further write during the walk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      scalar_r <= '0;
      acc_r    <= '0;
      vm_r     <= '0;
      vl_r     <= '0;
      fn_r     <= '0;
      idx_r    <= '0;
      err_r    <= 1'b0;
    end else if (accept) begin
      a_r      <= io.req_vec_a;
      b_r      <= io.req_vec_b;
      scalar_r <= io.req_scalar;
      vm_r     <= io.req_vm;
      vl_r     <= vl_clamp;
      fn_r     <= io.req_fn;
      idx_r    <= '0;
      acc_r    <= '0;
      err_r    <= fn_is_illegal(io.req_fn);
      res_r    <= (io.req_fn == VFN_REDSUM) ? '0 : io.req_vd_old;
    end else if (state_q == ST_RUN && !kill) begin
      idx_r <= idx_r + IW'(1);
      err_r <= err_r | alu_illegal;
      if (vm_r[idx_r]) begin
        if (fn_r == VFN_REDSUM) begin
          acc_r    <= alu_res;
          res_r[0] <= alu_res;
        end else begin
          res_r[idx_r] <= alu_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_vec_alu_seq.sv
// Randomized self-checking bench for riscv_vec_alu_seq with a vector-level
// reference model plus directed kill/reset/backpressure scenarios.
module tb_riscv_vec_alu_seq;

  localparam int NL = 8;
  localparam int LW = 32;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic kill = 1'b0;
  logic busy;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  riscv_vec_alu_seq_if #(.NLANES(NL), .LANE_W(LW), .VLW(VW)) bus ();

  riscv_vec_alu_seq #(.NLANES(NL), .LANE_W(LW), .VLW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .kill  (kill),
    .busy  (busy),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Whole-vector reference: what each element must hold after the operation
  function automatic logic [255:0] model_vec(input logic [3:0] fn, input logic [255:0] a,
      input logic [255:0] b, input logic [31:0] s, input logic [7:0] vm,
      input logic [3:0] vl, input logic [255:0] vd);
    int vlc;
    logic [255:0] r;
    logic [31:0] x, y, sum;
    vlc = (vl > 4'd8) ? 8 : int'(vl);
    r = '0;
    if (fn == 4'd10) begin
      sum = '0;
      for (int i = 0; i < vlc; i++) if (vm[i]) sum = sum + a[i*32 +: 32];
      r[31:0] = sum;
      return r;
    end
    for (int i = 0; i < 8; i++) begin
      x = a[i*32 +: 32];
      y = (fn >= 4'd5 && fn <= 4'd9) ? s : b[i*32 +: 32];
      if (i < vlc && vm[i]) begin
        case (fn)
          4'd0, 4'd5: r[i*32 +: 32] = x + y;
          4'd1, 4'd6: r[i*32 +: 32] = x - y;
          4'd2, 4'd7: r[i*32 +: 32] = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          4'd3, 4'd8: r[i*32 +: 32] = (x == y) ? 32'd1 : 32'd0;
          4'd4, 4'd9: r[i*32 +: 32] = x & y;
          default:    r[i*32 +: 32] = 32'd0;
        endcase
      end else begin
        r[i*32 +: 32] = vd[i*32 +: 32];
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*32 +: 32] = 32'h7FFF_FFFF;
        1:       v[i*32 +: 32] = 32'h8000_0000;
        2:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic drive_req(input logic [3:0] fn, input logic [255:0] a, input logic [255:0] b,
      input logic [31:0] s, input logic [7:0] vm, input logic [3:0] vl, input logic [255:0] vd);
    bus.req_val    = 1'b1;
    bus.req_fn     = fn;
    bus.req_vec_a  = a;
    bus.req_vec_b  = b;
    bus.req_scalar = s;
    bus.req_vm     = vm;
    bus.req_vl     = vl;
    bus.req_vd_old = vd;
  endtask

  // Request fields become don't-care after the accept edge
  task automatic scramble_req();
    bus.req_val    = 1'b0;
    bus.req_fn     = 4'($urandom);
    bus.req_vec_a  = rand_vec();
    bus.req_vec_b  = rand_vec();
    bus.req_scalar = $urandom;
    bus.req_vm     = 8'($urandom);
    bus.req_vl     = 4'($urandom);
    bus.req_vd_old = rand_vec();
  endtask

  task automatic run_op(input string tag, input logic [3:0] fn, input logic [255:0] a,
      input logic [255:0] b, input logic [31:0] s, input logic [7:0] vm, input logic [3:0] vl,
      input logic [255:0] vd, input int stall);
    logic [255:0] exp;
    int edges;
    int vlc;
    exp = model_vec(fn, a, b, s, vm, vl, vd);
    vlc = (vl > 4'd8) ? 8 : int'(vl);
    bus.resp_rdy = 1'b0;
    drive_req(fn, a, b, s, vm, vl, vd);
    check({tag, ".req_rdy"}, 256'(bus.req_rdy), 256'(1));
    @(posedge clk); #1;
    scramble_req();
    edges = 1;
    while (!bus.resp_val && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".latency"}, 256'(edges), 256'(vlc + 1));
    check({tag, ".vec"}, bus.resp_vec, exp);
    check({tag, ".err"}, 256'(bus.resp_err), 256'(fn > 4'd10));
    check({tag, ".busy_rdy"}, 256'({busy, bus.req_rdy}), 256'(2'b10));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check({tag, ".hold"}, 256'({bus.resp_val, bus.req_rdy}), 256'(2'b10));
      check({tag, ".hold_vec"}, bus.resp_vec, exp);
    end
    bus.resp_rdy = 1'b1;
    @(posedge clk); #1;
    bus.resp_rdy = 1'b0;
    check({tag, ".idle"}, 256'({bus.resp_val, bus.req_rdy, busy}), 256'(3'b010));
  endtask

  initial begin
    logic [255:0] a, b, vd;
    logic [3:0] fn;
    logic [31:0] s;
    logic seen;

    bus.resp_rdy = 1'b0;
    scramble_req();
    #1;
    check("reset_out", 256'({bus.req_rdy, busy, bus.resp_val, bus.resp_err}), 256'(4'b1000));
    check("reset_vec", bus.resp_vec, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADDV full length
    for (int i = 0; i < 8; i++) begin
      a[i*32 +: 32] = 32'(i);
      b[i*32 +: 32] = 32'd100;
      vd[i*32 +: 32] = 32'h5555_0000 + 32'(i);
    end
    run_op("addv_full", 4'd0, a, b, 32'd0, 8'hFF, 4'd8, vd, 0);

    // SLTX, masked, short vl
    a = rand_vec();
    a[0*32 +: 32] = 32'hFFFF_FFFD;
    a[1*32 +: 32] = 32'd7;
    a[2*32 +: 32] = 32'hFFFF_FFFF;
    a[3*32 +: 32] = 32'd0;
    a[4*32 +: 32] = 32'd9;
    vd = {8{32'hDEAD_BEEF}};
    run_op("sltx_mask", 4'd7, a, rand_vec(), 32'd0, 8'b0001_0101, 4'd5, vd, 1);

    // REDSUM with wrap
    a = rand_vec();
    a[0*32 +: 32] = 32'hFFFF_FFFF;
    a[1*32 +: 32] = 32'd2;
    a[2*32 +: 32] = 32'd3;
    a[3*32 +: 32] = 32'd4;
    run_op("redsum_wrap", 4'd10, a, rand_vec(), 32'd0, 8'h0F, 4'd4, rand_vec(), 0);

    // Backpressure
    run_op("backpressure", 4'd1, rand_vec(), rand_vec(), 32'd0, 8'hA5, 4'd6, rand_vec(), 5);

    // Boundaries: vl = 0, vl clamp, undefined fn, REDSUM vl = 0
    run_op("vl0_addv", 4'd0, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd0, rand_vec(), 0);
    run_op("vl15_addv", 4'd0, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd15, rand_vec(), 0);
    run_op("fn13", 4'd13, rand_vec(), rand_vec(), 32'd0, 8'h6B, 4'd6, rand_vec(), 0);
    run_op("redsum_vl0", 4'd10, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd0, rand_vec(), 0);

    // kill in the 3rd RUN cycle
    drive_req(4'd0, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd8, rand_vec());
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_run", 256'({bus.req_rdy, busy, bus.resp_val}), 256'(3'b100));
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      seen = seen | bus.resp_val;
    end
    check("kill_no_resp", 256'(seen), 256'(0));

    // kill in IDLE blocks acceptance
    drive_req(4'd0, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd3, rand_vec());
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    scramble_req();
    check("kill_idle", 256'({bus.req_rdy, busy}), 256'(2'b10));

    // kill in DONE beats resp_rdy and produces no later response
    drive_req(4'd2, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd0, rand_vec());
    @(posedge clk); #1;
    scramble_req();
    check("done_reached", 256'(bus.resp_val), 256'(1));
    kill = 1'b1;
    bus.resp_rdy = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    bus.resp_rdy = 1'b0;
    check("kill_done", 256'({bus.req_rdy, busy, bus.resp_val}), 256'(3'b100));

    // Asynchronous reset mid-RUN
    drive_req(4'd0, rand_vec(), rand_vec(), 32'd0, 8'hFF, 4'd8, rand_vec());
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_reset", 256'({bus.req_rdy, busy, bus.resp_val, bus.resp_err}), 256'(4'b1000));
    check("async_reset_vec", bus.resp_vec, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Randomized operations
    for (int t = 0; t < 60; t++) begin
      fn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
      a = rand_vec();
      b = ($urandom_range(0, 3) == 0) ? a : rand_vec();
      s = ($urandom_range(0, 2) == 0) ? a[31:0] : $urandom;
      run_op($sformatf("rand%0d_fn%0d", t, fn), fn, a, b, s, 8'($urandom),
             4'($urandom_range(0, 15)), rand_vec(), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_vec_alu_seq.md
# riscv_vec_alu_seq

Lane-serial sequencer for vector ALU operations in the riscvvec core datapath. It accepts one vector operation per request, latches the operands, and evaluates one 32-bit element per cycle over the active vector length, applying the element mask. It handles the multi-cycle REDSUM accumulation and returns the assembled 256-bit result over a valid/ready response channel. It sits between the vector issue logic and the vector register-file writeback.

## Interface
- NLANES, 8, number of 32-bit elements per vector register
- LANE_W, 32, element width in bits
- VLW, 4, width of the vector-length field; must be at least clog2(NLANES+1)

- clk  in  1  core clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready; high only in IDLE
- req_fn  in  4  operation code (see Operation)
- req_vec_a  in  NLANES*LANE_W  operand vector A
- req_vec_b  in  NLANES*LANE_W  operand vector B
- req_scalar  in  LANE_W  scalar operand for the X variants
- req_vm  in  NLANES  element mask; bit i enables element i
- req_vl  in  VLW  vector length; values above NLANES are clamped to NLANES
- req_vd_old  in  NLANES*LANE_W  previous destination value, used for inactive elements
- kill  in  1  synchronous abort
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_vec  out  NLANES*LANE_W  result vector
- resp_err  out  1  high with resp_val when req_fn was an undefined code
- busy  out  1  high whenever the state is not IDLE

## Operation
- **Opcodes:**
  - 0 ADDV, 1 SUBV, 2 SLTV, 3 SEQV, 4 ANDV: element-by-element, A op B.
  - 5 ADDX, 6 SUBX, 7 SLTX, 8 SEQX, 9 ANDX: A element op scalar.
  - 10 REDSUM: reduction sum of A.
  - 11–15: undefined.
- **Arithmetic rules:**
  - Add and subtract wrap modulo 2^32.
  - SLT is a signed comparison and produces 32'd1 or 32'd0.
  - SEQ produces 32'd1 or 32'd0.
- **Request handshake:**
  - A transfer occurs when req_val && req_rdy.
  - On transfer, all req_* fields are latched. The request inputs are don't-care afterwards.
- **Active elements:**
  - Element i is active iff i < vl_clamped and vm[i] = 1.
  - An inactive element takes the latched vd_old element.
- **Element walk:**
  - Element index i runs from 0 to vl_clamped-1, one element per RUN cycle.
  - Masked elements still consume a cycle. This keeps latency independent of the mask.
- **REDSUM:**
  - The accumulator is cleared on accept.
  - Each active element of A is added to it, wrapping modulo 2^32.
  - Result element 0 = accumulator; elements 1..NLANES-1 = 0. The mask and vd_old do not affect these zero elements.
- **Undefined fn:**
  - Active elements are written with 0; inactive elements take vd_old.
  - resp_err = 1.
- **States:**
  - IDLE:
    - On accept with vl_clamped > 0 → RUN.
    - On accept with vl_clamped = 0 → DONE.
  - RUN:
    - Each cycle, write element i; then if i = vl_clamped-1 → DONE, else i+1.
  - DONE:
    - resp_val = 1.
    - On resp_rdy → IDLE.
    - resp_vec and resp_err are held stable until then.
- **kill:**
  - In RUN or DONE, kill → IDLE at the next edge and no response is produced.
  - kill has priority over resp_rdy.
  - In IDLE, kill blocks acceptance that cycle.
- **vl = 0:**
  - resp_vec = vd_old for all ops except REDSUM.
  - REDSUM gives all zeros.

## Timing
- **Reset values:**
  - State = IDLE, element index = 0, accumulator = 0.
  - req_rdy = 1, busy = 0, resp_val = 0, resp_vec = 0, resp_err = 0.
  - Reset asserted mid-operation discards the operation immediately, without waiting for a clock edge.
- **Latency:**
  - resp_val rises vl_clamped+1 rising edges after the accept edge, counting the accept edge.
  - Examples: vl = 8 gives 9 edges; vl = 0 gives 1 edge.
- **Throughput:** no overlap between operations. req_rdy falls on the accept edge and returns one cycle after the response is taken.
- **Back-to-back:** the earliest next accept is one edge after the edge where resp_val && resp_rdy.
- **Combinational paths:** req_rdy and resp_val are pure state decodes, with no combinational path from req_val or resp_rdy.

## Structure
- **Shared package riscv_vec_pkg:**
  - Opcode localparams VFN_ADDV through VFN_REDSUM.
  - NLANES and LANE_W defaults.
  - State encoding ST_IDLE / ST_RUN / ST_DONE.
- **Sub-module riscv_vec_lane_alu:** combinational, 32-bit.
  - Inputs: fn, a, b.
  - Outputs: result and an illegal flag.
  - The sequencer selects b = scalar for the X variants and instantiates the lane ALU once.
- **Sequencer internals:**
  - Operand registers.
  - Element counter.
  - Result register, written one element per cycle.
  - REDSUM accumulator.
  - State register.

## Test plan
- **ADDV, full length:** vl = 8, vm = 0xFF, A[i] = i, B[i] = 100 → resp_vec[i] = 100+i; resp_val on the 9th edge after accept; resp_err = 0.
- **SLTX with mask and short vl:** vl = 5, vm = 0b10101, A = {-3, 7, -1, 0, 9, …}, scalar = 0, vd_old = 0xDEADBEEF → elements {1, DEADBEEF, 1, DEADBEEF, 0, DEADBEEF, DEADBEEF, DEADBEEF}.
- **REDSUM with wrap:** vl = 4, vm = 0xF, A = {0xFFFFFFFF, 2, 3, 4} → element 0 = 8, elements 1–7 = 0.
- **Response backpressure:** hold resp_rdy = 0 for 5 cycles → resp_val and resp_vec stable and req_rdy = 0 throughout; IDLE one edge after resp_rdy = 1.
- **kill mid-run, then reset:** kill in the 3rd RUN cycle of vl = 8 → no resp_val, req_rdy = 1 the next cycle. Separately, reset low during RUN → all outputs at reset values immediately.
- **Edge cases:** vl = 0 ADDV → resp_vec = vd_old after 1 edge. vl = 15 → treated as 8. fn = 13 → active elements 0, resp_err = 1.
